pc_stack: RTL and testbench
===========================

# pc_stack

Parametrised program counter with a hardware return-address stack for the CPU fetch stage. It drives the instruction-memory address and supports sequential increment, absolute jump, PC-relative branch, subroutine call and return, and pipeline stall. Stack overflow and underflow are detected, and each raises a sticky error flag for the control unit.

## Interface
Parameters:
- ADDR_W, 8: program address width; must match instruction-memory depth.
- OFS_W, 6: branch offset width, two's complement, OFS_W <= ADDR_W.
- STACK_DEPTH, 4: return-stack entries, >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  freeze PC and stack; all commands ignored.
- count  in  1  increment PC.
- load  in  1  absolute jump to addr_in.
- branch  in  1  relative jump by offset.
- call  in  1  push return address, jump to addr_in.
- ret  in  1  pop return address into PC.
- addr_in  in  ADDR_W  jump/call target.
- offset  in  OFS_W  signed branch displacement.
- err_clr  in  1  clear sticky flags.
- addr_out  out  ADDR_W  current program address (registered).
- top_addr  out  ADDR_W  stack top entry; 0 when empty.
- depth  out  $clog2(STACK_DEPTH+1)  entries in use.
- stack_full  out  1  depth == STACK_DEPTH.
- stack_empty  out  1  depth == 0.
- ovf  out  1  sticky: call attempted while full.
- unf  out  1  sticky: ret attempted while empty.

## Operation
- Reset values: addr_out = 0, depth = 0, top_addr = 0, stack_empty = 1, stack_full = 0, ovf = 0, unf = 0. Stack contents are don't-care.
- Command priority, highest first: stall > ret > call > load > branch > count > hold. Exactly one action executes per cycle. Lower-priority strobes asserted in the same cycle are ignored.
- ret, not empty: addr_out <= top entry, depth - 1.
- ret, empty: unf <= 1, PC and stack hold.
- call, not full: push (addr_out + 1) mod 2^ADDR_W, addr_out <= addr_in, depth + 1.
- call, full: ovf <= 1, no push, PC holds.
- load: addr_out <= addr_in.
- branch: addr_out <= (addr_out + sign_extend(offset)) mod 2^ADDR_W.
- count: addr_out <= (addr_out + 1) mod 2^ADDR_W.
- Wrap-around:
  - Increment wraps from 2^ADDR_W-1 to 0.
  - Branch wraps in both directions.
  - The return address pushed from 2^ADDR_W-1 is 0.
- Stack is LIFO, implemented as a register array with a depth pointer. The top entry is index depth-1.
- err_clr clears ovf and unf. It is honoured even during stall. If a new error event coincides with err_clr, the set wins.
- stall has no effect on err_clr. It blocks ovf/unf setting because commands are ignored.
- Mid-operation reset returns all outputs to their reset values immediately, without waiting for a clock edge.

## Timing
- Every command takes effect on the rising edge at which it is sampled high. addr_out, depth and flags show the result in the following cycle.
- Single-cycle latency for all operations. Back-to-back commands are accepted every cycle with no bubbles.
- top_addr, stack_full, stack_empty are combinational decodes of registered state. They are glitch-free relative to clk and carry no extra latency.
- After call, ret is accepted on the very next cycle. After call then immediate ret, addr_out returns to call_site+1 two edges after the call.
- Strobes are level-sampled. Holding count high for N edges advances addr_out by N.

## Test plan
- Reset/count: assert rst, release, then hold count for 5 edges. Required: addr_out 0,1,2,3,4,5. With addr_out = 0xFF, count once; required: addr_out = 0x00.
- Branch: addr_out = 0x10 with offset = 6'h3E (-2), then from 0x02 with offset = 6'h3C (-4). Required: addr_out = 0x0E, then 0xFE.
- Nested call/ret: from 0x20, call 0x40. From 0x40, call 0x80. Then ret, ret. Required:
  - addr_out 0x40, 0x80, 0x41, 0x21.
  - depth 1, 2, 1, 0.
  - top_addr 0x21, 0x41, 0x21, 0x00.
- Overflow/underflow: issue 5 calls with STACK_DEPTH = 4. Required: 5th call leaves PC unchanged, ovf = 1, depth = 4. Then 5 rets. Required: 5th ret leaves PC unchanged, unf = 1. Pulse err_clr; required: ovf = unf = 0.
- Priority/stall:
  - count+load+branch together: load wins.
  - call+ret together with depth 1: ret wins, depth 0.
  - stall with call high: no change, depth unchanged.
  - err_clr during stall: flags cleared.
- Async reset mid-stack: depth = 3, addr_out = 0x55, assert rst between edges. Required: all outputs at reset values before the next edge. Required after release: count gives addr_out = 1, stack_empty = 1.

Source files
------------

// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack for the fetch stage.
// Supports count, load, relative branch, call/ret and stall, with sticky stack error flags.
module pc_stack #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned OFS_W       = 6,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    input  logic                             count,
    input  logic                             load,
    input  logic                             branch,
    input  logic                             call,
    input  logic                             ret,
    input  logic [ADDR_W-1:0]                addr_in,
    input  logic [OFS_W-1:0]                 offset,
    input  logic                             err_clr,
    output logic [ADDR_W-1:0]                addr_out,
    output logic [ADDR_W-1:0]                top_addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             ovf,
    output logic                             unf
);

    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        CmdHold,
        CmdCount,
        CmdBranch,
        CmdLoad,
        CmdCall,
        CmdRet
    } cmd_e;

    cmd_e               cmd;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               ovf_set, unf_set;
    logic               push;
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  ofs_ext;
    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   push_idx;
    logic               full, empty;

    assign pc_inc   = addr_q + ADDR_W'(1);
    assign ofs_ext  = ADDR_W'($signed(offset));
    assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty    = (depth_q == '0);
    assign top_idx  = IDX_W'(depth_q - DEPTH_W'(1));
    assign push_idx = IDX_W'(depth_q);

    // Priority select of the single action taken this cycle.
    always_comb begin
        cmd = CmdHold;
        if (!stall) begin
            if (ret) begin
                cmd = CmdRet;
            end else if (call) begin
                cmd = CmdCall;
            end else if (load) begin
                cmd = CmdLoad;
            end else if (branch) begin
                cmd = CmdBranch;
            end else if (count) begin
                cmd = CmdCount;
            end
        end
    end

    always_comb begin
        addr_d  = addr_q;
        depth_d = depth_q;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (cmd)
            CmdRet: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    addr_d  = stack_q[top_idx];
                    depth_d = depth_q - DEPTH_W'(1);
                end
            end
            CmdCall: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    push    = 1'b1;
                    addr_d  = addr_in;
                    depth_d = depth_q + DEPTH_W'(1);
                end
            end
            CmdLoad:   addr_d = addr_in;
            CmdBranch: addr_d = addr_q + ofs_ext;
            CmdCount:  addr_d = pc_inc;
            default:   ;
        endcase
        // A new error event wins over a simultaneous clear.
        ovf_d = (ovf_q & ~err_clr) | ovf_set;
        unf_d = (unf_q & ~err_clr) | unf_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry contents are don't-care after reset; only the depth pointer is reset.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign addr_out    = addr_q;
    assign depth       = depth_q;
    assign top_addr    = empty ? '0 : stack_q[top_idx];
    assign stack_full  = full;
    assign stack_empty = empty;
    assign ovf         = ovf_q;
    assign unf         = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: directed scenarios plus random commands, checked through a
// scoreboard fed by a queue-based reference model.
module tb_pc_stack;

    localparam int ADDR_W      = 8;
    localparam int OFS_W       = 6;
    localparam int STACK_DEPTH = 4;
    localparam int AMOD        = 1 << ADDR_W;
    localparam int OMOD        = 1 << OFS_W;

    logic              clk;
    logic              rst;
    logic              stall, count, load, branch, call, ret, err_clr;
    logic [ADDR_W-1:0] addr_in;
    logic [OFS_W-1:0]  offset;
    logic [ADDR_W-1:0] addr_out, top_addr;
    logic [2:0]        depth;
    logic              stack_full, stack_empty, ovf, unf;

    pc_stack #(
        .ADDR_W     (ADDR_W),
        .OFS_W      (OFS_W),
        .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .count      (count),
        .load       (load),
        .branch     (branch),
        .call       (call),
        .ret        (ret),
        .addr_in    (addr_in),
        .offset     (offset),
        .err_clr    (err_clr),
        .addr_out   (addr_out),
        .top_addr   (top_addr),
        .depth      (depth),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .ovf        (ovf),
        .unf        (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int dep;
        int top;
        int full;
        int empty;
        int ovf;
        int unf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int   m_pc  = 0;
    int   m_stk[$];
    int   m_ovf = 0;
    int   m_unf = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_step();
        int sx;
        if (rst) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            int n_ovf = m_ovf & ~int'(err_clr);
            int n_unf = m_unf & ~int'(err_clr);
            if (!stall) begin
                if (ret) begin
                    if (m_stk.size() == 0) n_unf = 1;
                    else m_pc = m_stk.pop_back();
                end else if (call) begin
                    if (m_stk.size() == STACK_DEPTH) n_ovf = 1;
                    else begin
                        m_stk.push_back((m_pc + 1) % AMOD);
                        m_pc = int'(addr_in);
                    end
                end else if (load) begin
                    m_pc = int'(addr_in);
                end else if (branch) begin
                    sx = int'(offset);
                    if (sx >= OMOD / 2) sx = sx - OMOD;
                    m_pc = (m_pc + sx + AMOD) % AMOD;
                end else if (count) begin
                    m_pc = (m_pc + 1) % AMOD;
                end
            end
            m_ovf = n_ovf;
            m_unf = n_unf;
        end
    endtask

    // Drive one cycle of stimulus from a negedge, record expectation, wait for next negedge.
    task automatic cycle(input logic st, input logic cn, input logic ld, input logic br,
                         input logic cl, input logic rt, input logic ec,
                         input int a, input int o);
        exp_t e;
        stall   = st;
        count   = cn;
        load    = ld;
        branch  = br;
        call    = cl;
        ret     = rt;
        err_clr = ec;
        addr_in = ADDR_W'(a);
        offset  = OFS_W'(o);
        model_step();
        e.pc    = m_pc;
        e.dep   = m_stk.size();
        e.top   = (m_stk.size() == 0) ? 0 : m_stk[$];
        e.full  = (m_stk.size() == STACK_DEPTH) ? 1 : 0;
        e.empty = (m_stk.size() == 0) ? 1 : 0;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every edge presents a new state; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("addr_out", int'(addr_out), e.pc);
                chk("depth", int'(depth), e.dep);
                chk("top_addr", int'(top_addr), e.top);
                chk("stack_full", int'(stack_full), e.full);
                chk("stack_empty", int'(stack_empty), e.empty);
                chk("ovf", int'(ovf), e.ovf);
                chk("unf", int'(unf), e.unf);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected < 500000", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        stall = 0; count = 0; load = 0; branch = 0; call = 0; ret = 0; err_clr = 0;
        addr_in = '0;
        offset  = '0;
        idle();
        idle();
        rst = 1'b0;

        // Reset / count
        repeat (5) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("count_5", int'(addr_out), 5);
        cycle(0, 0, 1, 0, 0, 0, 0, 'hFF, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("count_wrap", int'(addr_out), 'h00);

        // Branch in both directions through wrap
        cycle(0, 0, 1, 0, 0, 0, 0, 'h10, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 'h3E);
        chk("branch_m2", int'(addr_out), 'h0E);
        cycle(0, 0, 1, 0, 0, 0, 0, 'h02, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 'h3C);
        chk("branch_wrap", int'(addr_out), 'hFE);

        // Nested call / ret
        cycle(0, 0, 1, 0, 0, 0, 0, 'h20, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 'h40, 0);
        chk("call1_top", int'(top_addr), 'h21);
        cycle(0, 0, 0, 0, 1, 0, 0, 'h80, 0);
        chk("call2_top", int'(top_addr), 'h41);
        chk("call2_depth", int'(depth), 2);
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("ret1_pc", int'(addr_out), 'h41);
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("ret2_pc", int'(addr_out), 'h21);
        chk("ret2_top", int'(top_addr), 0);

        // Overflow then underflow
        cycle(0, 0, 1, 0, 0, 0, 0, 'h10, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0, 0, 'h30 + i, 0);
        chk("ovf_pc", int'(addr_out), 'h33);
        chk("ovf_flag", int'(ovf), 1);
        chk("ovf_depth", int'(depth), 4);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("unf_pc", int'(addr_out), 'h11);
        chk("unf_flag", int'(unf), 1);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("clr_ovf", int'(ovf), 0);
        chk("clr_unf", int'(unf), 0);

        // Priority and stall
        cycle(0, 1, 1, 1, 0, 0, 0, 'h33, 5);
        chk("load_wins", int'(addr_out), 'h33);
        cycle(0, 0, 0, 0, 1, 0, 0, 'h60, 0);
        cycle(0, 0, 0, 0, 1, 1, 0, 'h70, 0);
        chk("ret_wins_pc", int'(addr_out), 'h34);
        chk("ret_wins_depth", int'(depth), 0);
        cycle(0, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("set_beats_clr", int'(unf), 1);
        cycle(1, 0, 0, 0, 1, 0, 0, 'h99, 0);
        chk("stall_pc", int'(addr_out), 'h34);
        chk("stall_depth", int'(depth), 0);
        cycle(1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("stall_clr", int'(unf), 0);

        // Asynchronous reset with a populated stack
        cycle(0, 0, 0, 0, 1, 0, 0, 'h10, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 'h20, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 'h30, 0);
        cycle(0, 0, 1, 0, 0, 0, 0, 'h55, 0);
        chk("pre_rst_depth", int'(depth), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_addr", int'(addr_out), 0);
        chk("arst_depth", int'(depth), 0);
        chk("arst_top", int'(top_addr), 0);
        chk("arst_empty", int'(stack_empty), 1);
        chk("arst_full", int'(stack_full), 0);
        idle();
        rst = 1'b0;
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_pc", int'(addr_out), 1);
        chk("post_rst_empty", int'(stack_empty), 1);

        // Random commands
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(9) == 0, $urandom_range(1) == 1, $urandom_range(5) == 0,
                  $urandom_range(4) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                  $urandom_range(15) == 0, int'($urandom_range(AMOD - 1)),
                  int'($urandom_range(OMOD - 1)));
        end

        idle();
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
